// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined RISC-V immediate generator.
// IMM_RVC_EN widens the format select to 4 bits and adds the compressed formats.
package imm_gen_pkg;

`ifdef IMM_RVC_EN
    localparam int IMM_SEL_W = 4;
`else
    localparam int IMM_SEL_W = 3;
`endif

    localparam logic [IMM_SEL_W-1:0] IMM_J     = IMM_SEL_W'(3'd0);
    localparam logic [IMM_SEL_W-1:0] IMM_I     = IMM_SEL_W'(3'd1);
    localparam logic [IMM_SEL_W-1:0] IMM_B     = IMM_SEL_W'(3'd2);
    localparam logic [IMM_SEL_W-1:0] IMM_S     = IMM_SEL_W'(3'd3);
    localparam logic [IMM_SEL_W-1:0] IMM_U     = IMM_SEL_W'(3'd4);
    localparam logic [IMM_SEL_W-1:0] IMM_SHAMT = IMM_SEL_W'(3'd5);
    localparam logic [IMM_SEL_W-1:0] IMM_CSR   = IMM_SEL_W'(3'd6);

`ifdef IMM_RVC_EN
    localparam logic [IMM_SEL_W-1:0] IMM_CI    = 4'd8;
    localparam logic [IMM_SEL_W-1:0] IMM_CJ    = 4'd9;
    localparam logic [IMM_SEL_W-1:0] IMM_CB    = 4'd10;
`endif

    function automatic bit imm_xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate decode: instruction word and format select to XLEN immediate.
// With IMM_RVC_EN defined the compressed CI/CJ/CB formats are also decoded.
module imm_gen_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SEL_W-1:0] imm_sel,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [31:0] imm32_s;
    logic        zext_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = ^instr[1:0];

    // Build a 32-bit immediate, then widen it by sign or zero extension.
    always_comb begin
        imm32_s = 32'd0;
        zext_s  = 1'b0;
        err     = 1'b0;
        case (imm_sel)
            IMM_J:     imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            IMM_I:     imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_B:     imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            IMM_S:     imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_U:     imm32_s = {instr[31:12], 12'd0};
            IMM_SHAMT: begin
                zext_s = 1'b1;
                if (XLEN == 64) begin
                    imm32_s = {26'd0, instr[25:20]};
                end else begin
                    imm32_s = {27'd0, instr[24:20]};
                end
            end
            IMM_CSR: begin
                zext_s  = 1'b1;
                imm32_s = {27'd0, instr[19:15]};
            end
`ifdef IMM_RVC_EN
            IMM_CI:    imm32_s = {{26{instr[12]}}, instr[12], instr[6:2]};
            // CJ bits appear scrambled in the encoding: offset[11|4|9:8|10|6|7|3:1|5].
            IMM_CJ:    imm32_s = {{20{instr[12]}}, instr[12], instr[8], instr[10:9],
                                  instr[6], instr[7], instr[2], instr[11], instr[5:3], 1'b0};
            IMM_CB:    imm32_s = {{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                                  instr[11:10], instr[4:3], 1'b0};
`endif
            default: begin
                imm32_s = 32'd0;
                err     = 1'b1;
            end
        endcase
        if (zext_s) begin
            imm = XLEN'(imm32_s);
        end else begin
            imm = XLEN'($signed(imm32_s));
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with PC+IMM target, one output register and a skid entry.
// Optional compressed formats are enabled by defining IMM_RVC_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = IMM_SEL_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTR,
    input  logic [SEL_W-1:0] IMM_SEL,
    input  logic [XLEN-1:0]  IN_PC,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMM_OUT,
    output logic [XLEN-1:0]  TARGET_OUT,
    output logic             SEL_ERR
);

    if (!imm_xlen_legal(XLEN) || (SEL_W != IMM_SEL_W)) begin : g_bad_param
        $error("imm_gen_pipe: XLEN must be 32 or 64 and SEL_W must match the build");
    end

    logic [XLEN-1:0] new_imm_s;
    logic [XLEN-1:0] new_tgt_s;
    logic            new_err_s;
    logic            in_fire_s;
    logic            out_load_s;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [XLEN-1:0] out_tgt_q,   out_tgt_d;
    logic            out_err_q,   out_err_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic [XLEN-1:0] skid_tgt_q,  skid_tgt_d;
    logic            skid_err_q,  skid_err_d;
    logic            in_ready_q,  in_ready_d;

    imm_gen_core #(
        .XLEN (XLEN)
    ) u_core (
        .instr   (INSTR),
        .imm_sel (IMM_SEL),
        .imm     (new_imm_s),
        .err     (new_err_s)
    );

    assign new_tgt_s  = IN_PC + new_imm_s;
    assign in_fire_s  = IN_VALID & in_ready_q;
    assign out_load_s = ~out_valid_q | OUT_READY;

    // Output/skid steering: the output register refills from skid first to keep FIFO order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tgt_d    = out_tgt_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tgt_d   = skid_tgt_q;
        skid_err_d   = skid_err_q;
        if (out_load_s) begin
            if (skid_valid_q) begin
                out_valid_d = 1'b1;
                out_imm_d   = skid_imm_q;
                out_tgt_d   = skid_tgt_q;
                out_err_d   = skid_err_q;
                if (in_fire_s) begin
                    skid_valid_d = 1'b1;
                    skid_imm_d   = new_imm_s;
                    skid_tgt_d   = new_tgt_s;
                    skid_err_d   = new_err_s;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_imm_d   = new_imm_s;
                out_tgt_d   = new_tgt_s;
                out_err_d   = new_err_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_valid_d = 1'b1;
                skid_imm_d   = new_imm_s;
                skid_tgt_d   = new_tgt_s;
                skid_err_d   = new_err_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // Pipeline state; ready resets high so it is asserted in the first cycle after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tgt_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tgt_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tgt_q    <= out_tgt_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tgt_q   <= skid_tgt_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign IN_READY   = in_ready_q & ~RST;
    assign OUT_VALID  = out_valid_q;
    assign IMM_OUT    = out_imm_q;
    assign TARGET_OUT = out_tgt_q;
    assign SEL_ERR    = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance on a shared clock.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam logic [IMM_SEL_W-1:0] SEL_BAD = IMM_SEL_W'(3'b111);

    logic clk;
    logic rst;

    logic                 v32, rdy32, ov32, or32, err32;
    logic [31:0]          instr32, pc32, imm32, tgt32;
    logic [IMM_SEL_W-1:0] sel32;

    logic                 v64, rdy64, ov64, or64, err64;
    logic [31:0]          instr64;
    logic [63:0]          pc64, imm64, tgt64;
    logic [IMM_SEL_W-1:0] sel64;

    int n_vec;
    int n_err;

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .CLK(clk), .RST(rst), .IN_VALID(v32), .IN_READY(rdy32), .INSTR(instr32),
        .IMM_SEL(sel32), .IN_PC(pc32), .OUT_VALID(ov32), .OUT_READY(or32),
        .IMM_OUT(imm32), .TARGET_OUT(tgt32), .SEL_ERR(err32)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .CLK(clk), .RST(rst), .IN_VALID(v64), .IN_READY(rdy64), .INSTR(instr64),
        .IMM_SEL(sel64), .IN_PC(pc64), .OUT_VALID(ov64), .OUT_READY(or64),
        .IMM_OUT(imm64), .TARGET_OUT(tgt64), .SEL_ERR(err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [11:0] val);
        return {val, 20'h00013};
    endfunction

    task send32(input logic [31:0] ins, input logic [IMM_SEL_W-1:0] sel, input logic [31:0] pc);
        v32 = 1'b1; instr32 = ins; sel32 = sel; pc32 = pc;
        tick;
        v32 = 1'b0;
    endtask

    task send64(input logic [31:0] ins, input logic [IMM_SEL_W-1:0] sel, input logic [63:0] pc);
        v64 = 1'b1; instr64 = ins; sel64 = sel; pc64 = pc;
        tick;
        v64 = 1'b0;
    endtask

    task res32(input string tag, input logic [31:0] eimm, input logic [31:0] etgt,
               input logic eerr);
        chk({tag, "_ov"},  {63'd0, ov32}, 64'd1);
        chk({tag, "_imm"}, {32'd0, imm32}, {32'd0, eimm});
        chk({tag, "_tgt"}, {32'd0, tgt32}, {32'd0, etgt});
        chk({tag, "_err"}, {63'd0, err32}, {63'd0, eerr});
    endtask

    task res64(input string tag, input logic [63:0] eimm, input logic [63:0] etgt);
        chk({tag, "_ov"},  {63'd0, ov64}, 64'd1);
        chk({tag, "_imm"}, imm64, eimm);
        chk({tag, "_tgt"}, tgt64, etgt);
        chk({tag, "_err"}, {63'd0, err64}, 64'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        v32 = 1'b0; instr32 = 32'd0; sel32 = IMM_J; pc32 = 32'd0; or32 = 1'b1;
        v64 = 1'b0; instr64 = 32'd0; sel64 = IMM_J; pc64 = 64'd0; or64 = 1'b1;

        // Reset state
        #1;
        chk("rst_rdy32", {63'd0, rdy32}, 64'd0);
        chk("rst_rdy64", {63'd0, rdy64}, 64'd0);
        tick;
        tick;
        chk("rst_ov32",  {63'd0, ov32}, 64'd0);
        chk("rst_imm32", {32'd0, imm32}, 64'd0);
        chk("rst_tgt32", {32'd0, tgt32}, 64'd0);
        chk("rst_err32", {63'd0, err32}, 64'd0);
        chk("rst_ov64",  {63'd0, ov64}, 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy32", {63'd0, rdy32}, 64'd1);
        chk("post_rst_rdy64", {63'd0, rdy64}, 64'd1);
        tick;

        // XLEN=32 formats
        send32(32'h0080006F, IMM_J, 32'h0000_0100);
        res32("j32", 32'h0000_0008, 32'h0000_0108, 1'b0);
        send32(32'hFE000EE3, IMM_B, 32'h0000_0200);
        res32("b32", 32'hFFFF_FFFC, 32'h0000_01FC, 1'b0);
        send32(32'h800000B7, IMM_U, 32'h8000_0000);
        res32("u32", 32'h8000_0000, 32'h0000_0000, 1'b0);
        send32(32'h03F00013, IMM_SHAMT, 32'h0000_0010);
        res32("shamt32", 32'h0000_001F, 32'h0000_002F, 1'b0);
        send32(32'hFFFFFFFF, IMM_CSR, 32'h0000_0000);
        res32("csr32", 32'h0000_001F, 32'h0000_001F, 1'b0);
        send32(32'h80000F80, IMM_S, 32'h0000_1000);
        res32("s32", 32'hFFFF_F81F, 32'h0000_081F, 1'b0);
        send32(32'hFFFFFFFF, SEL_BAD, 32'h0000_0040);
        res32("ill32", 32'h0000_0000, 32'h0000_0040, 1'b1);
        send32(32'hFFF00093, IMM_I, 32'h0000_0000);
        res32("i32", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // XLEN=64 formats
        send64(32'hFFF00093, IMM_I, 64'h0000_0000_0000_1000);
        res64("i64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0FFF);
        send64(32'h800000B7, IMM_U, 64'h0000_0001_0000_0000);
        res64("u64", 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000);
        send64(32'h03F00013, IMM_SHAMT, 64'h0000_0000_0000_0000);
        res64("shamt64", 64'h0000_0000_0000_003F, 64'h0000_0000_0000_003F);

        // Backpressure: 3 beats against a stalled output
        tick;
        chk("drain_ov", {63'd0, ov32}, 64'd0);
        or32 = 1'b0; v32 = 1'b1; instr32 = mk_i(12'd1); sel32 = IMM_I; pc32 = 32'd0;
        chk("bp_rdy_a", {63'd0, rdy32}, 64'd1);
        tick;
        chk("bp_a_ov",  {63'd0, ov32}, 64'd1);
        chk("bp_a_imm", {32'd0, imm32}, 64'd1);
        chk("bp_a_rdy", {63'd0, rdy32}, 64'd1);
        instr32 = mk_i(12'd2);
        tick;
        chk("bp_b_imm", {32'd0, imm32}, 64'd1);
        chk("bp_b_rdy", {63'd0, rdy32}, 64'd0);
        instr32 = mk_i(12'd3);
        tick;
        chk("bp_hold1_imm", {32'd0, imm32}, 64'd1);
        chk("bp_hold1_rdy", {63'd0, rdy32}, 64'd0);
        tick;
        chk("bp_hold2_imm", {32'd0, imm32}, 64'd1);
        chk("bp_hold2_rdy", {63'd0, rdy32}, 64'd0);
        or32 = 1'b1;
        tick;
        chk("bp_rel_ov",  {63'd0, ov32}, 64'd1);
        chk("bp_rel_imm", {32'd0, imm32}, 64'd2);
        chk("bp_rel_rdy", {63'd0, rdy32}, 64'd1);
        tick;
        chk("bp_c_ov",  {63'd0, ov32}, 64'd1);
        chk("bp_c_imm", {32'd0, imm32}, 64'd3);
        v32 = 1'b0;
        tick;
        chk("bp_empty_ov", {63'd0, ov32}, 64'd0);

        // Reset with both entries full
        or32 = 1'b0; v32 = 1'b1; instr32 = mk_i(12'd4); pc32 = 32'h0000_1000;
        tick;
        instr32 = mk_i(12'd5);
        tick;
        v32 = 1'b0;
        chk("full_rdy", {63'd0, rdy32}, 64'd0);
        chk("full_imm", {32'd0, imm32}, 64'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", {63'd0, rdy32}, 64'd0);
        tick;
        chk("mid_rst_ov",  {63'd0, ov32}, 64'd0);
        chk("mid_rst_imm", {32'd0, imm32}, 64'd0);
        chk("mid_rst_tgt", {32'd0, tgt32}, 64'd0);
        chk("mid_rst_err", {63'd0, err32}, 64'd0);
        chk("mid_rst_rdy2", {63'd0, rdy32}, 64'd0);
        rst = 1'b0; or32 = 1'b1;
        #1;
        chk("after_rst_rdy", {63'd0, rdy32}, 64'd1);
        tick;
        chk("after_rst_ov1", {63'd0, ov32}, 64'd0);
        tick;
        chk("after_rst_ov2", {63'd0, ov32}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
